// File: rtl/clock_pkg.sv
// Shared types, limits and wrap helpers for the alarm clock datapath and sequencers.
// Field widths are 5/6/6 for hours/minutes/seconds; all counters wrap at their own limit.
package clock_pkg;

   typedef enum logic [2:0] {
      RUN        = 3'd0,
      SET_HR     = 3'd1,
      SET_MIN    = 3'd2,
      SET_AL_HR  = 3'd3,
      SET_AL_MIN = 3'd4
   } set_state_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RING   = 2'd1,
      SNOOZE = 2'd2
   } alarm_state_t;

   localparam int HR_W  = 5;
   localparam int MIN_W = 6;
   localparam int SEC_W = 6;

   localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;
   localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
   localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

   function automatic logic [5:0] inc_wrap6(input logic [5:0] v, input logic [5:0] max_v);
      return (v >= max_v) ? 6'd0 : v + 6'd1;
   endfunction

   function automatic logic [HR_W-1:0] inc_hr(input logic [HR_W-1:0] v);
      return (v >= HR_MAX) ? 5'd0 : v + 5'd1;
   endfunction

endpackage

// File: rtl/alarm_sequencer.sv
// Alarm ring/snooze FSM with one shared 10-bit down-counter for ring timeout and snooze delay.
// Ringing/buzzer are registered from the next state, so they follow match/stop by one clock.
module alarm_sequencer
   import clock_pkg::*;
#(
   parameter int SNOOZE_MIN = 5,
   parameter int RING_SEC   = 60
) (
   input  logic clk,
   input  logic reset,
   input  logic i_match,
   input  logic i_tick,
   input  logic i_snooze,
   input  logic i_stop,
   input  logic i_alarm_en,
   output logic o_ringing,
   output logic o_buzzer
);

   localparam logic [9:0] RING_LOAD   = 10'(RING_SEC);
   localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_MIN * 60);

   alarm_state_t r_state, w_state_nxt;
   logic [9:0]   r_cnt, w_cnt_nxt;
   logic         r_ringing;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      // Disarming wins over everything, including a pending match.
      if (!i_alarm_en) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_match) begin
                  w_state_nxt = RING;
                  w_cnt_nxt   = RING_LOAD;
               end
            end
            RING: begin
               if (i_stop) begin
                  w_state_nxt = IDLE;
               end else if (i_snooze) begin
                  w_state_nxt = SNOOZE;
                  w_cnt_nxt   = SNOOZE_LOAD;
               end else if (i_tick) begin
                  if (r_cnt <= 10'd1) w_state_nxt = IDLE;
                  else                w_cnt_nxt   = r_cnt - 10'd1;
               end
            end
            SNOOZE: begin
               if (i_stop) begin
                  w_state_nxt = IDLE;
               end else if (i_tick) begin
                  if (r_cnt <= 10'd1) begin
                     w_state_nxt = RING;
                     w_cnt_nxt   = RING_LOAD;
                  end else begin
                     w_cnt_nxt = r_cnt - 10'd1;
                  end
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_ringing <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_ringing <= (w_state_nxt == RING);
      end
   end

   assign o_ringing = r_ringing;
   assign o_buzzer  = r_ringing;

endmodule

// File: rtl/alarm_clock_controller.sv
// Alarm clock sequencer: time/alarm registers, set-mode FSM and display enables.
// Match is registered one clock after the tick update, so the buzzer rises two clocks after it.
module alarm_clock_controller
   import clock_pkg::*;
#(
   parameter int SNOOZE_MIN   = 5,
   parameter int RING_SEC     = 60,
   parameter int ALARM_RST_HR = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tick_1s,
   input  logic              half_second,
   input  logic              mode_btn,
   input  logic              inc_btn,
   input  logic              alarm_btn,
   input  logic              snooze_btn,
   input  logic              stop_btn,
   output logic [HR_W-1:0]   hours,
   output logic [MIN_W-1:0]  minutes,
   output logic [SEC_W-1:0]  seconds,
   output logic [HR_W-1:0]   alarm_hours,
   output logic [MIN_W-1:0]  alarm_minutes,
   output logic [2:0]        mode,
   output logic              show_alarm,
   output logic              blink_hr,
   output logic              blink_min,
   output logic              alarm_en,
   output logic              ringing,
   output logic              buzzer
);

   set_state_t       r_mode, w_mode_nxt;
   logic [HR_W-1:0]  r_hr, w_hr_nxt, r_al_hr;
   logic [MIN_W-1:0] r_min, w_min_nxt, r_al_min;
   logic [SEC_W-1:0] r_sec, w_sec_nxt;
   logic             r_alarm_en, r_tick_upd, r_match;
   logic             r_show, r_blink_hr, r_blink_min;
   logic             w_tick, w_inc, w_alarm_en_nxt;

   always_comb begin
      w_mode_nxt = r_mode;
      case (r_mode)
         RUN:        if (mode_btn) w_mode_nxt = SET_HR;
         SET_HR:     if (mode_btn) w_mode_nxt = SET_MIN;
         SET_MIN:    if (mode_btn) w_mode_nxt = SET_AL_HR;
         SET_AL_HR:  if (mode_btn) w_mode_nxt = SET_AL_MIN;
         SET_AL_MIN: if (mode_btn) w_mode_nxt = RUN;
         default:    w_mode_nxt = RUN;
      endcase
   end

   // Time runs everywhere except while the time fields themselves are being edited.
   assign w_tick         = tick_1s && (r_mode == RUN || r_mode == SET_AL_HR || r_mode == SET_AL_MIN);
   assign w_inc          = inc_btn && !mode_btn;
   assign w_alarm_en_nxt = r_alarm_en ^ alarm_btn;

   always_comb begin
      w_sec_nxt = r_sec;
      w_min_nxt = r_min;
      w_hr_nxt  = r_hr;
      if (w_tick) begin
         w_sec_nxt = inc_wrap6(r_sec, SEC_MAX);
         if (r_sec == SEC_MAX) begin
            w_min_nxt = inc_wrap6(r_min, MIN_MAX);
            if (r_min == MIN_MAX) w_hr_nxt = inc_hr(r_hr);
         end
      end else if (w_inc && r_mode == SET_HR) begin
         w_hr_nxt = inc_hr(r_hr);
      end else if (w_inc && r_mode == SET_MIN) begin
         w_min_nxt = inc_wrap6(r_min, MIN_MAX);
      end
      if (w_mode_nxt == SET_HR && r_mode != SET_HR) w_sec_nxt = '0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mode      <= RUN;
         r_hr        <= '0;
         r_min       <= '0;
         r_sec       <= '0;
         r_al_hr     <= 5'(ALARM_RST_HR);
         r_al_min    <= '0;
         r_alarm_en  <= 1'b0;
         r_tick_upd  <= 1'b0;
         r_match     <= 1'b0;
         r_show      <= 1'b0;
         r_blink_hr  <= 1'b0;
         r_blink_min <= 1'b0;
      end else begin
         r_mode     <= w_mode_nxt;
         r_hr       <= w_hr_nxt;
         r_min      <= w_min_nxt;
         r_sec      <= w_sec_nxt;
         r_alarm_en <= w_alarm_en_nxt;
         if (w_inc && r_mode == SET_AL_HR)  r_al_hr  <= inc_hr(r_al_hr);
         if (w_inc && r_mode == SET_AL_MIN) r_al_min <= inc_wrap6(r_al_min, MIN_MAX);
         // Only a tick-driven update can produce a match; edits never do.
         r_tick_upd <= w_tick;
         r_match    <= r_tick_upd && (r_sec == '0) && (r_hr == r_al_hr) && (r_min == r_al_min)
                       && r_alarm_en && (r_mode != SET_HR) && (r_mode != SET_MIN);
         r_show      <= (w_mode_nxt == SET_AL_HR) || (w_mode_nxt == SET_AL_MIN);
         r_blink_hr  <= half_second && ((w_mode_nxt == SET_HR) || (w_mode_nxt == SET_AL_HR));
         r_blink_min <= half_second && ((w_mode_nxt == SET_MIN) || (w_mode_nxt == SET_AL_MIN));
      end
   end

   alarm_sequencer #(
      .SNOOZE_MIN (SNOOZE_MIN),
      .RING_SEC   (RING_SEC)
   ) u_alarm_sequencer (
      .clk        (clk),
      .reset      (reset),
      .i_match    (r_match),
      .i_tick     (tick_1s),
      .i_snooze   (snooze_btn),
      .i_stop     (stop_btn),
      .i_alarm_en (w_alarm_en_nxt),
      .o_ringing  (ringing),
      .o_buzzer   (buzzer)
   );

   assign hours         = r_hr;
   assign minutes       = r_min;
   assign seconds       = r_sec;
   assign alarm_hours   = r_al_hr;
   assign alarm_minutes = r_al_min;
   assign mode          = r_mode;
   assign show_alarm    = r_show;
   assign blink_hr      = r_blink_hr;
   assign blink_min     = r_blink_min;
   assign alarm_en      = r_alarm_en;

endmodule

// File: tb/tb_alarm_clock_controller.sv
// Bench for alarm_clock_controller: seconds-of-day reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_alarm_clock_controller;

   localparam int SNOOZE_MIN   = 5;
   localparam int RING_SEC     = 60;
   localparam int ALARM_RST_HR = 6;

   logic clk = 1'b0, reset = 1'b0;
   logic tick_1s = 1'b0, half_second = 1'b0, mode_btn = 1'b0, inc_btn = 1'b0;
   logic alarm_btn = 1'b0, snooze_btn = 1'b0, stop_btn = 1'b0;
   logic [4:0] hours, alarm_hours;
   logic [5:0] minutes, seconds, alarm_minutes;
   logic [2:0] mode;
   logic show_alarm, blink_hr, blink_min, alarm_en, ringing, buzzer;

   int checks = 0;
   int errors = 0;
   int hs_cnt = 0;

   always #5 clk = ~clk;

   alarm_clock_controller #(
      .SNOOZE_MIN(SNOOZE_MIN), .RING_SEC(RING_SEC), .ALARM_RST_HR(ALARM_RST_HR)
   ) dut (
      .clk(clk), .reset(reset), .tick_1s(tick_1s), .half_second(half_second),
      .mode_btn(mode_btn), .inc_btn(inc_btn), .alarm_btn(alarm_btn),
      .snooze_btn(snooze_btn), .stop_btn(stop_btn),
      .hours(hours), .minutes(minutes), .seconds(seconds),
      .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes), .mode(mode),
      .show_alarm(show_alarm), .blink_hr(blink_hr), .blink_min(blink_min),
      .alarm_en(alarm_en), .ringing(ringing), .buzzer(buzzer)
   );

   // Reference model: time as seconds of day, alarm FSM as 0 idle / 1 ring / 2 snooze.
   int m_tsec, m_alh, m_alm, m_mode, m_ast, m_left;
   bit m_en, m_tick_prev, m_match, m_show, m_bh, m_bm;

   task model_init;
      m_tsec = 0; m_alh = ALARM_RST_HR; m_alm = 0; m_mode = 0; m_ast = 0; m_left = 0;
      m_en = 0; m_tick_prev = 0; m_match = 0; m_show = 0; m_bh = 0; m_bm = 0;
   endtask

   task model_step;
      bit counting, mnew, en_new;
      counting = (m_mode == 0 || m_mode == 3 || m_mode == 4);
      mnew = m_tick_prev && (m_tsec % 60 == 0) && (m_tsec / 60 == m_alh * 60 + m_alm)
             && m_en && m_mode != 1 && m_mode != 2;
      en_new = m_en ^ alarm_btn;
      if (!en_new) m_ast = 0;
      else if (m_ast == 0) begin
         if (m_match) begin m_ast = 1; m_left = RING_SEC; end
      end else if (m_ast == 1) begin
         if (stop_btn) m_ast = 0;
         else if (snooze_btn) begin m_ast = 2; m_left = SNOOZE_MIN * 60; end
         else if (tick_1s) begin m_left--; if (m_left == 0) m_ast = 0; end
      end else begin
         if (stop_btn) m_ast = 0;
         else if (tick_1s) begin
            m_left--;
            if (m_left == 0) begin m_ast = 1; m_left = RING_SEC; end
         end
      end
      m_tick_prev = tick_1s && counting;
      if (tick_1s && counting) m_tsec = (m_tsec + 1) % 86400;
      if (inc_btn && !mode_btn) begin
         case (m_mode)
            1: m_tsec = (m_tsec + 3600) % 86400;
            2: m_tsec = (m_tsec / 3600) * 3600 + ((m_tsec / 60 % 60 + 1) % 60) * 60 + m_tsec % 60;
            3: m_alh = (m_alh + 1) % 24;
            4: m_alm = (m_alm + 1) % 60;
            default: ;
         endcase
      end
      if (mode_btn) begin
         m_mode = (m_mode + 1) % 5;
         if (m_mode == 1) m_tsec = m_tsec - m_tsec % 60;
      end
      m_en = en_new;
      m_match = mnew;
      m_show = (m_mode >= 3);
      m_bh = half_second && (m_mode == 1 || m_mode == 3);
      m_bm = half_second && (m_mode == 2 || m_mode == 4);
   endtask

   always @(posedge clk) begin
      if (!reset) model_init();
      else        model_step();
   end

   always @(negedge reset) model_init();

   always @(posedge clk) begin
      #2;
      hs_cnt++;
      if (hs_cnt % 7 == 0) half_second = ~half_second;
   end

   logic [36:0] got_v, exp_v;
   always @(negedge clk) begin
      got_v = {hours, minutes, seconds, alarm_hours, alarm_minutes, mode,
               show_alarm, blink_hr, blink_min, alarm_en, ringing, buzzer};
      exp_v = {5'(m_tsec / 3600), 6'(m_tsec / 60 % 60), 6'(m_tsec % 60), 5'(m_alh), 6'(m_alm),
               3'(m_mode), m_show, m_bh, m_bm, m_en, m_ast == 1, m_ast == 1};
      checks++;
      if (got_v !== exp_v) begin
         errors++;
         $display("FAIL cycle_model t=%0t got %0d:%0d:%0d al %0d:%0d mode %0d flags %b required %0d:%0d:%0d al %0d:%0d mode %0d flags %b",
                  $time, got_v[36:32], got_v[31:26], got_v[25:20], got_v[19:15], got_v[14:9],
                  got_v[8:6], got_v[5:0], exp_v[36:32], exp_v[31:26], exp_v[25:20],
                  exp_v[19:15], exp_v[14:9], exp_v[8:6], exp_v[5:0]);
      end
   end

   task check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d required %0d", name, got, exp);
      end
   endtask

   task cyc(input bit t, input bit m, input bit i, input bit a, input bit sn, input bit st);
      tick_1s = t; mode_btn = m; inc_btn = i; alarm_btn = a; snooze_btn = sn; stop_btn = st;
      @(posedge clk);
      #2;
      tick_1s = 0; mode_btn = 0; inc_btn = 0; alarm_btn = 0; snooze_btn = 0; stop_btn = 0;
   endtask

   task ticks(input int n);
      repeat (n) cyc(1, 0, 0, 0, 0, 0);
   endtask

   task press_mode(input int n);
      repeat (n) cyc(0, 1, 0, 0, 0, 0);
   endtask

   task press_inc(input int n);
      repeat (n) cyc(0, 0, 1, 0, 0, 0);
   endtask

   task idle(input int n);
      repeat (n) cyc(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      model_init();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b1;
      check("rst_hours", hours, 0);
      check("rst_seconds", seconds, 0);
      check("rst_alarm_hours", alarm_hours, 6);
      check("rst_mode", mode, 0);
      check("rst_alarm_en", alarm_en, 0);
      check("rst_buzzer", buzzer, 0);

      // Full day of ticks in RUN.
      ticks(86399);
      check("day_h_86399", hours, 23);
      check("day_m_86399", minutes, 59);
      check("day_s_86399", seconds, 59);
      ticks(1);
      check("day_h_wrap", hours, 0);
      check("day_m_wrap", minutes, 0);
      check("day_s_wrap", seconds, 0);
      check("day_alarm_h", alarm_hours, 6);
      check("day_mode", mode, 0);

      // Hour editing with wrap; time frozen in SET_HR.
      press_mode(1);
      check("sethr_mode", mode, 1);
      press_inc(25);
      check("sethr_hours", hours, 1);
      ticks(3);
      check("sethr_frozen_s", seconds, 0);
      press_mode(4);
      check("back_run_mode", mode, 0);
      ticks(1);
      check("resume_s", seconds, 1);

      // Alarm 07:30, armed; time preset 07:29:59.
      press_mode(3);
      check("show_alarm", show_alarm, 1);
      press_inc(1);
      press_mode(1);
      press_inc(30);
      press_mode(1);
      check("al_h", alarm_hours, 7);
      check("al_m", alarm_minutes, 30);
      cyc(0, 0, 0, 1, 0, 0);
      check("armed", alarm_en, 1);
      press_mode(1);
      press_inc(6);
      press_mode(1);
      press_inc(29);
      press_mode(3);
      ticks(59);
      check("pre_h", hours, 7);
      check("pre_m", minutes, 29);
      check("pre_s", seconds, 59);
      ticks(1);
      check("match_edge_buzz", buzzer, 0);
      idle(1);
      check("match_plus1_buzz", buzzer, 0);
      idle(1);
      check("match_plus2_buzz", buzzer, 1);
      ticks(RING_SEC - 1);
      check("ring_59_ticks", ringing, 1);
      ticks(1);
      check("ring_timeout", buzzer, 0);

      // Alarm 07:32, snooze then stop+snooze together.
      press_mode(4);
      press_inc(2);
      press_mode(1);
      ticks(60);
      idle(2);
      check("ring2_on", ringing, 1);
      cyc(0, 0, 0, 0, 1, 0);
      check("snooze_buzz", buzzer, 0);
      ticks(SNOOZE_MIN * 60 - 1);
      check("snooze_299", ringing, 0);
      ticks(1);
      check("snooze_300_ring", ringing, 1);
      cyc(0, 0, 0, 0, 1, 1);
      check("stop_wins", ringing, 0);
      ticks(SNOOZE_MIN * 60 + 5);
      check("stop_is_idle", ringing, 0);

      // Alarm 07:43, disarm while ringing, re-arm, preset back and ring again.
      press_mode(4);
      press_inc(11);
      press_mode(1);
      ticks(60);
      idle(2);
      check("ring3_on", ringing, 1);
      cyc(0, 0, 0, 1, 0, 0);
      check("disarm_en", alarm_en, 0);
      check("disarm_ring", ringing, 0);
      cyc(0, 0, 0, 1, 0, 0);
      check("rearm_en", alarm_en, 1);
      press_mode(2);
      press_inc(59);
      check("min_wrap_m", minutes, 42);
      check("min_wrap_no_carry", hours, 7);
      press_mode(3);
      ticks(60);
      idle(2);
      check("ring4_on", buzzer, 1);

      // Async reset mid-ring, no clock edge.
      #1;
      reset = 1'b0;
      #1;
      check("async_rst_buzz", buzzer, 0);
      check("async_rst_ring", ringing, 0);
      check("async_rst_hours", hours, 0);
      check("async_rst_al_min", alarm_minutes, 0);
      @(posedge clk);
      #2;
      reset = 1'b1;

      // Mode and inc together in SET_MIN.
      press_mode(2);
      press_inc(3);
      cyc(0, 1, 1, 0, 0, 0);
      check("mode_inc_mode", mode, 3);
      check("mode_inc_min", minutes, 3);
      press_mode(2);
      check("final_mode", mode, 0);
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
